// File: rtl/uart_rx.sv
// 8N1 UART receiver with a level-valid/ack handshake, sticky overrun and a one-cycle framing-error pulse.
// All line decisions use the 2-flop synchronized line and sample at mid-bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  input  logic       i_Rx_Ack,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_DV,
  output logic       o_Rx_ready,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err,
  output logic       o_Overrun
);

  localparam logic [9:0] HALF_M1 = 10'(CLKS_PER_BIT / 2 - 1);
  localparam logic [9:0] FULL_M1 = 10'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  sync;
  logic        rx_s;
  logic [9:0]  cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        half_hit, bit_hit;

  assign rx_s       = sync[1];
  assign half_hit   = (cnt == HALF_M1);
  assign bit_hit    = (cnt == FULL_M1);
  assign o_Rx_ready = ~o_Rx_DV;

  // Synchronizer resets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) sync <= 2'b11;
    else         sync <= {sync[0], i_Rx_Serial};
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (half_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_hit && idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_hit) state_nxt = CLEANUP;
      // Hold here while the line is low so a break cannot retrigger a start.
      CLEANUP: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      o_Rx_Byte   <= '0;
      o_Rx_DV     <= 1'b0;
      o_Rx_Active <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Overrun   <= 1'b0;
    end else begin
      o_Frame_Err <= 1'b0;
      if (i_Rx_Ack && o_Rx_DV) begin
        o_Rx_DV   <= 1'b0;
        o_Overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_s) o_Rx_Active <= 1'b1;
        end
        START: begin
          if (half_hit) begin
            cnt <= '0;
            if (rx_s) o_Rx_Active <= 1'b0;
          end else cnt <= cnt + 10'd1;
        end
        DATA: begin
          if (bit_hit) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            idx        <= idx + 3'd1;
          end else cnt <= cnt + 10'd1;
        end
        STOP: begin
          if (bit_hit) begin
            cnt <= '0;
            // A same-cycle ack frees the holding register, so the new byte wins over the clear above.
            if (rx_s) begin
              if (!o_Rx_DV || i_Rx_Ack) begin
                o_Rx_Byte <= shreg;
                o_Rx_DV   <= 1'b1;
              end else o_Overrun <= 1'b1;
            end else o_Frame_Err <= 1'b1;
          end else cnt <= cnt + 10'd1;
        end
        CLEANUP: begin
          cnt         <= '0;
          o_Rx_Active <= 1'b0;
        end
        default: begin
          cnt         <= '0;
          idx         <= '0;
          o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames against a byte-level model,
// and a slow-rate instance fed by a behavioural transmitter gated on o_Rx_ready.
module tb_uart_rx;
  localparam int CPB   = 16;
  localparam int CPB_L = 868;

  logic       gclk = 1'b0;
  logic       rst  = 1'b1;
  logic [1:0] rx_line = 2'b11;
  logic [1:0] ack = 2'b00;
  logic [7:0] rbyte [2];
  logic [1:0] dv, rdy, act, fe, ovr;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt [2] = '{0, 0};
  int act_cnt = 0;

  // byte-level model of DUT 0
  logic [7:0] e_byte;
  logic       e_dv, e_ovr;
  int         e_fe;

  always #5 gclk = ~gclk;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_dut (
    .i_Clock(gclk), .i_Reset(rst), .i_Rx_Serial(rx_line[0]), .i_Rx_Ack(ack[0]),
    .o_Rx_Byte(rbyte[0]), .o_Rx_DV(dv[0]), .o_Rx_ready(rdy[0]), .o_Rx_Active(act[0]),
    .o_Frame_Err(fe[0]), .o_Overrun(ovr[0]));

  uart_rx #(.CLKS_PER_BIT(CPB_L)) u_lb (
    .i_Clock(gclk), .i_Reset(rst), .i_Rx_Serial(rx_line[1]), .i_Rx_Ack(ack[1]),
    .o_Rx_Byte(rbyte[1]), .o_Rx_DV(dv[1]), .o_Rx_ready(rdy[1]), .o_Rx_Active(act[1]),
    .o_Frame_Err(fe[1]), .o_Overrun(ovr[1]));

  always @(negedge gclk) begin
    if (fe[0]) fe_cnt[0]++;
    if (fe[1]) fe_cnt[1]++;
    if (act[0]) act_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge gclk);
  endtask

  // Drives start, 8 data bits LSB first, stop; the line is left at the stop level.
  task automatic send(input int w, input logic [7:0] b, input logic stop, input int cpb);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line[w] = f[i];
      cyc(cpb);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) e_fe++;
    else if (!e_dv) begin
      e_byte = b;
      e_dv   = 1'b1;
    end else e_ovr = 1'b1;
  endtask

  task automatic ack0();
    ack[0] = 1'b1;
    cyc(1);
    ack[0] = 1'b0;
    if (e_dv) begin
      e_dv  = 1'b0;
      e_ovr = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".byte"}, 32'(rbyte[0]), 32'(e_byte));
    chk({tag, ".dv"}, 32'(dv[0]), 32'(e_dv));
    chk({tag, ".ready"}, 32'(rdy[0]), e_dv ? 32'd0 : 32'd1);
    chk({tag, ".ovr"}, 32'(ovr[0]), 32'(e_ovr));
    chk({tag, ".fe"}, 32'(fe_cnt[0]), 32'(e_fe));
    chk({tag, ".active"}, 32'(act[0]), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    int         a0, waited;
    logic [7:0] lb_bytes [3];
    lb_bytes = '{8'h00, 8'hFF, 8'h55};
    e_byte = 8'h00; e_dv = 1'b0; e_ovr = 1'b0; e_fe = 0;

    cyc(3);
    check_model("reset");
    chk("reset.lb_ready", 32'(rdy[1]), 32'd1);
    rst = 1'b0;
    cyc(4);

    // start-bit glitch
    a0 = act_cnt;
    rx_line[0] = 1'b0;
    cyc(4);
    rx_line[0] = 1'b1;
    cyc(CPB);
    chk("glitch.active_pulsed", 32'(act_cnt - a0 > 0), 32'd1);
    check_model("glitch");

    // basic frame and handshake
    send(0, 8'hA5, 1'b1, CPB);
    cyc(2);
    model_frame(8'hA5, 1'b1);
    check_model("a5");
    cyc(20);
    chk("a5.hold_dv", 32'(dv[0]), 32'd1);
    ack0();
    chk("a5.ack_dv", 32'(dv[0]), 32'd0);
    check_model("a5.acked");

    // framing error followed by a held-low break
    send(0, 8'h3C, 1'b0, CPB);
    model_frame(8'h3C, 1'b0);
    a0 = act_cnt;
    cyc(40);
    chk("brk.no_restart", 32'(act_cnt - a0), 32'd0);
    rx_line[0] = 1'b1;
    cyc(CPB);
    check_model("brk");

    // overrun
    send(0, 8'h11, 1'b1, CPB);
    cyc(3);
    model_frame(8'h11, 1'b1);
    send(0, 8'h22, 1'b1, CPB);
    cyc(3);
    model_frame(8'h22, 1'b1);
    check_model("ovr");
    ack0();
    check_model("ovr.acked");

    // reset during data bit 3 of 0xFF
    a0 = fe_cnt[0];
    rx_line[0] = 1'b0;
    cyc(CPB);
    rx_line[0] = 1'b1;
    cyc(3 * CPB + CPB / 2);
    chk("rst.active_before", 32'(act[0]), 32'd1);
    rst = 1'b1;
    cyc(1);
    e_byte = 8'h00; e_dv = 1'b0; e_ovr = 1'b0;
    check_model("rst");
    cyc(2);
    rst = 1'b0;
    cyc(2 * CPB);
    check_model("rst.after");
    send(0, 8'h5A, 1'b1, CPB);
    cyc(2);
    model_frame(8'h5A, 1'b1);
    check_model("rst.5a");
    ack0();

    // random frames, random acks, occasional bad stop bits
    for (int i = 0; i < 30; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send(0, b, stop, CPB);
      if (!stop) rx_line[0] = 1'b1;
      cyc(4);
      model_frame(b, stop);
      check_model("rand");
      if ($urandom_range(0, 1) == 1) begin
        ack0();
        chk("rand.ack_dv", 32'(dv[0]), 32'(e_dv));
      end
      cyc($urandom_range(1, 20));
    end

    // slow-rate loopback, transmitter waits on o_Rx_ready
    foreach (lb_bytes[k]) begin
      waited = 0;
      while (!rdy[1] && waited < 2000) begin
        cyc(1);
        waited++;
      end
      chk("lb.ready_wait", 32'(rdy[1]), 32'd1);
      send(1, lb_bytes[k], 1'b1, CPB_L);
      cyc(4);
      chk("lb.byte", 32'(rbyte[1]), 32'(lb_bytes[k]));
      chk("lb.dv", 32'(dv[1]), 32'd1);
      ack[1] = 1'b1;
      cyc(1);
      ack[1] = 1'b0;
      chk("lb.ack_dv", 32'(dv[1]), 32'd0);
    end
    chk("lb.fe", 32'(fe_cnt[1]), 32'd0);
    chk("lb.ovr", 32'(ovr[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
